ff_bank: RTL and testbench
==========================

FF_BANK -- requirements
Module: ff_bank

Interface
REQ-001 Parameter WIDTH, default 8: number of independent flip-flop bits; legal range 1 to 64.
REQ-002 Parameter RESET_VAL, default 0: WIDTH-bit value loaded into q on reset.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 Port en, input, 1: update enable; when 0 all state holds.
REQ-006 Port mode, input, 2: bank mode, 00=JK, 01=SR, 10=T, 11=D.
REQ-007 Port a, input, WIDTH: per-bit primary input, acting as J, S, T or D by mode.
REQ-008 Port b, input, WIDTH: per-bit secondary input, acting as K or R; ignored in T and D modes.
REQ-009 Port err_clr, input, 1: clears sr_err.
REQ-010 Port q, output, WIDTH: registered state.
REQ-011 Port q_, output, WIDTH: bitwise complement of q, combinational.
REQ-012 Port changed, output, WIDTH: registered mask of bits whose q value changed at the last clock edge.
REQ-013 Port sr_err, output, 1: sticky flag for an illegal SR input.

Function
REQ-014 Each bit i SHALL update independently from a[i], b[i] and q[i] at every rising clk edge where rst_n=1 and en=1, with a latency of 1 cycle.
REQ-015 In JK mode {a,b}: 00 holds, 01 writes 0, 10 writes 1, 11 toggles; the result SHALL never be X.
REQ-016 In SR mode {a,b}: 00 holds, 01 writes 0, 10 writes 1, 11 holds q[i] unchanged.
REQ-017 In T mode: a[i]=1 toggles and a[i]=0 holds.
REQ-018 In D mode: q[i] SHALL load a[i].
REQ-019 mode SHALL be sampled at the same edge as a and b; a mode change takes effect on the first edge where it is presented, with no pipeline delay.
REQ-020 When en=0, q SHALL hold, changed SHALL load all zeros, and sr_err SHALL be unaffected by a and b.
REQ-021 When en=1, changed SHALL load q_next XOR q, so an edge that produces no change loads all zeros.
REQ-022 sr_err SHALL set at an edge where en=1, mode=SR and any bit has a[i]&b[i]=1.
REQ-023 sr_err SHALL clear at an edge where err_clr=1; when set and clear occur in the same cycle, set wins.
REQ-024 q_ SHALL equal ~q at all times, including during reset.
REQ-025 No state other than q, changed and sr_err SHALL exist; no combinational path SHALL run from a, b or mode to any output.

Reset
REQ-026 At an edge where rst_n=0: q=RESET_VAL, changed=0, sr_err=0.
REQ-027 Reset SHALL take priority over en, mode, a, b and err_clr.
REQ-028 Reset SHALL be honoured mid-operation at any edge, and the first edge after rst_n returns to 1 performs a normal update.
REQ-029 Before the first reset edge, output values are undefined; the bench SHALL apply reset for 2 or more cycles.

Verification (WIDTH=8, RESET_VAL=8'hA5)
REQ-030 Reset then release: q=A5, q_=5A, changed=00, sr_err=0.
REQ-031 JK mode from q=A5, a=F0, b=0F → q=F0, changed=55; then a=FF, b=FF → q=0F, changed=FF.
REQ-032 SR mode from q=0F, a=30, b=11, which is illegal on bit 4 → q=2E, sr_err=1; next edge err_clr=1 with the same a and b → sr_err stays 1; then with legal inputs and err_clr=1 → sr_err=0.
REQ-033 T mode from q=2E, a=81 for 2 edges → q=AF, then q=2E; changed=81 on each edge. Then en=0 with a=FF → q holds and changed=00.
REQ-034 D mode with a=3C → q=3C. Next edge with mode=T and a=01 → q=3D, confirming zero-delay mode switching.
REQ-035 Mid-operation reset: rst_n=0 for 1 edge while en=1, mode=D, a=00, err_clr=0 and sr_err=1 → q=A5, changed=00, sr_err=0.

Source files
------------

// File: rtl/ff_bank.sv
// Bank of WIDTH independent flip-flops with a shared mode (JK/SR/T/D),
// a per-edge change mask and a sticky flag for illegal SR inputs.

module ff_bank_bit (
    input  logic [1:0] mode,
    input  logic       a,
    input  logic       b,
    input  logic       q,
    output logic       q_nxt
);
    localparam logic [1:0] M_JK = 2'b00;
    localparam logic [1:0] M_SR = 2'b01;
    localparam logic [1:0] M_T  = 2'b10;

    always_comb begin
        q_nxt = q;
        case (mode)
            M_JK: begin
                case ({a, b})
                    2'b01:   q_nxt = 1'b0;
                    2'b10:   q_nxt = 1'b1;
                    2'b11:   q_nxt = ~q;
                    default: q_nxt = q;
                endcase
            end
            // SR 11 is illegal; the bit holds and the bank raises sr_err
            M_SR: begin
                case ({a, b})
                    2'b01:   q_nxt = 1'b0;
                    2'b10:   q_nxt = 1'b1;
                    default: q_nxt = q;
                endcase
            end
            M_T:     q_nxt = a ? ~q : q;
            default: q_nxt = a;
        endcase
    end
endmodule

module ff_bank #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             err_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_,
    output logic [WIDTH-1:0] changed,
    output logic             sr_err
);
    localparam logic [1:0] M_SR = 2'b01;

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] chg_q, chg_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] q_nxt;
    logic             sr_set;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        ff_bank_bit u_bit (
            .mode  (mode),
            .a     (a[i]),
            .b     (b[i]),
            .q     (q_q[i]),
            .q_nxt (q_nxt[i])
        );
    end

    assign sr_set = en && (mode == M_SR) && (|(a & b));

    always_comb begin
        q_d   = en ? q_nxt : q_q;
        chg_d = en ? (q_nxt ^ q_q) : '0;
        // set beats clear when both land on the same edge
        err_d = sr_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q   <= RESET_VAL;
            chg_q <= '0;
            err_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            chg_q <= chg_d;
            err_q <= err_d;
        end
    end

    assign q       = q_q;
    assign q_      = ~q_q;
    assign changed = chg_q;
    assign sr_err  = err_q;
endmodule

// File: tb/tb_ff_bank.sv
// Table-driven + randomized check of ff_bank (WIDTH=8, RESET_VAL=A5)
// using an expected-result queue filled at drive time.

module tb_ff_bank;
    localparam int         W  = 8;
    localparam logic [7:0] RV = 8'hA5;

    logic         clk = 1'b0;
    logic         rst_n, en, err_clr;
    logic [1:0]   mode;
    logic [W-1:0] a, b;
    logic [W-1:0] q, q_, changed;
    logic         sr_err;

    ff_bank #(.WIDTH(W), .RESET_VAL(RV)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a), .b(b),
        .err_clr(err_clr), .q(q), .q_(q_), .changed(changed), .sr_err(sr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n, en;
        logic [1:0] mode;
        logic [7:0] a, b;
        logic       clr;
        logic [7:0] eq, ec;
        logic       ee;
    } vec_t;

    typedef struct {
        logic [7:0] q, c;
        logic       e;
        int         id;
    } exp_t;

    vec_t vt [22];
    exp_t sb [$];
    int   total = 0;
    int   bad   = 0;

    logic [7:0] mq, mc;
    logic       me;

    function automatic logic [7:0] mdl_next(logic [1:0] md, logic [7:0] ai, logic [7:0] bi, logic [7:0] qi);
        logic [7:0] n;
        for (int i = 0; i < 8; i++) begin
            if (md == 2'b11)       n[i] = ai[i];
            else if (md == 2'b10)  n[i] = qi[i] ^ ai[i];
            else if (ai[i] && bi[i]) n[i] = (md == 2'b00) ? !qi[i] : qi[i];
            else if (ai[i])        n[i] = 1'b1;
            else if (bi[i])        n[i] = 1'b0;
            else                   n[i] = qi[i];
        end
        return n;
    endfunction

    task automatic drive(input logic r, input logic e, input logic [1:0] md,
                         input logic [7:0] ai, input logic [7:0] bi, input logic c,
                         input logic [7:0] eq, input logic [7:0] ec, input logic ee, input int id);
        exp_t x;
        @(negedge clk);
        rst_n = r; en = e; mode = md; a = ai; b = bi; err_clr = c;
        x.q = eq; x.c = ec; x.e = ee; x.id = id;
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        total++;
        if (q !== x.q) begin bad++; $display("FAIL q id=%0d got=%h exp=%h", x.id, q, x.q); end
        total++;
        if (q_ !== ~x.q) begin bad++; $display("FAIL q_ id=%0d got=%h exp=%h", x.id, q_, ~x.q); end
        total++;
        if (changed !== x.c) begin bad++; $display("FAIL changed id=%0d got=%h exp=%h", x.id, changed, x.c); end
        total++;
        if (sr_err !== x.e) begin bad++; $display("FAIL sr_err id=%0d got=%b exp=%b", x.id, sr_err, x.e); end
    endtask

    task automatic model_step(input logic r, input logic e, input logic [1:0] md,
                              input logic [7:0] ai, input logic [7:0] bi, input logic c);
        logic [7:0] n;
        if (!r) begin
            mq = RV; mc = 8'h00; me = 1'b0;
        end else begin
            n  = e ? mdl_next(md, ai, bi, mq) : mq;
            mc = n ^ mq;
            mq = n;
            if (e && md == 2'b01 && (ai & bi) != 8'h00) me = 1'b1;
            else if (c) me = 1'b0;
        end
    endtask

    initial begin
        //          rst en mode   a      b      clr  q      chg    err
        vt[0]  = '{0, 0, 2'b11, 8'h00, 8'h00, 0, 8'hA5, 8'h00, 0};
        vt[1]  = '{0, 0, 2'b11, 8'h00, 8'h00, 0, 8'hA5, 8'h00, 0};
        vt[2]  = '{1, 0, 2'b00, 8'hFF, 8'hFF, 0, 8'hA5, 8'h00, 0};
        vt[3]  = '{1, 1, 2'b00, 8'hF0, 8'h0F, 0, 8'hF0, 8'h55, 0};
        vt[4]  = '{1, 1, 2'b00, 8'hFF, 8'hFF, 0, 8'h0F, 8'hFF, 0};
        vt[5]  = '{1, 1, 2'b01, 8'h30, 8'h11, 0, 8'h2E, 8'h21, 1};
        vt[6]  = '{1, 1, 2'b01, 8'h30, 8'h11, 1, 8'h2E, 8'h00, 1};
        vt[7]  = '{1, 1, 2'b01, 8'h00, 8'h00, 1, 8'h2E, 8'h00, 0};
        vt[8]  = '{1, 1, 2'b10, 8'h81, 8'h00, 0, 8'hAF, 8'h81, 0};
        vt[9]  = '{1, 1, 2'b10, 8'h81, 8'h00, 0, 8'h2E, 8'h81, 0};
        vt[10] = '{1, 0, 2'b10, 8'hFF, 8'h00, 0, 8'h2E, 8'h00, 0};
        vt[11] = '{1, 1, 2'b11, 8'h3C, 8'h00, 0, 8'h3C, 8'h12, 0};
        vt[12] = '{1, 1, 2'b10, 8'h01, 8'h00, 0, 8'h3D, 8'h01, 0};
        vt[13] = '{1, 1, 2'b01, 8'h03, 8'h03, 0, 8'h3D, 8'h00, 1};
        vt[14] = '{0, 1, 2'b11, 8'h00, 8'h00, 0, 8'hA5, 8'h00, 0};
        vt[15] = '{1, 1, 2'b11, 8'h00, 8'h00, 0, 8'h00, 8'hA5, 0};
        vt[16] = '{0, 1, 2'b01, 8'hFF, 8'hFF, 1, 8'hA5, 8'h00, 0};
        vt[17] = '{1, 0, 2'b01, 8'hFF, 8'hFF, 0, 8'hA5, 8'h00, 0};
        vt[18] = '{1, 1, 2'b01, 8'hFF, 8'hFF, 0, 8'hA5, 8'h00, 1};
        vt[19] = '{1, 0, 2'b01, 8'hFF, 8'hFF, 1, 8'hA5, 8'h00, 0};
        vt[20] = '{1, 1, 2'b00, 8'h00, 8'h00, 0, 8'hA5, 8'h00, 0};
        vt[21] = '{1, 1, 2'b01, 8'h5A, 8'h00, 0, 8'hFF, 8'h5A, 0};

        rst_n = 1'b0; en = 1'b0; mode = 2'b11; a = '0; b = '0; err_clr = 1'b0;

        for (int i = 0; i < 22; i++)
            drive(vt[i].rst_n, vt[i].en, vt[i].mode, vt[i].a, vt[i].b, vt[i].clr,
                  vt[i].eq, vt[i].ec, vt[i].ee, i);

        // randomized tail against the behavioural model, continuing from the table state
        mq = vt[21].eq; mc = vt[21].ec; me = vt[21].ee;
        for (int k = 0; k < 60; k++) begin
            logic       r, e, c;
            logic [1:0] md;
            logic [7:0] ai, bi;
            r  = ($urandom_range(0, 19) != 0);
            e  = ($urandom_range(0, 3) != 0);
            c  = ($urandom_range(0, 4) == 0);
            md = 2'($urandom_range(0, 3));
            ai = 8'($urandom);
            bi = 8'($urandom);
            if (md == 2'b01 && $urandom_range(0, 1) == 1) bi = bi & ~ai;
            model_step(r, e, md, ai, bi, c);
            drive(r, e, md, ai, bi, c, mq, mc, me, 100 + k);
        end

        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
